packet_receive_monitor: RTL
===========================

Name: packet_receive_monitor

Overview:
- Downstream of the stimulus/selection stage, on the ejection side of the 49-router network.
- Watches every router's local output packet and detects each new arrival.
- Logs each arrival as {router index, payload, latency since injection} into a small event FIFO.
- Shows the FIFO head on three active-low 7-segment displays; a key press steps through the logged events.

Parameters:
- N_ROUTERS, 49, number of routers monitored.
- PKT_W, 13, packet width: bit PKT_W-1 is valid, bits PKT_W-2:0 are payload.
- IDX_W, 6, router index width.
- DEPTH, 8, event FIFO entries (power of two).
- LAT_W, 8, latency counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_routers  in  N_ROUTERS*PKT_W  router r's packet occupies bits [r*PKT_W +: PKT_W], r = 0..48.
- inject  in  1  level high while stimulus is being driven into the network.
- key_next  in  1  raw key level; a press pops the FIFO head.
- sw_clear  in  1  synchronous flush of FIFO, overflow flag and latency counter.
- evt_count  out  IDX_W  number of entries in the FIFO (0..DEPTH).
- overflow  out  1  sticky flag: an arrival was dropped.
- hex_router_hi  out  7  tens digit of head router index, active-low segments.
- hex_router_lo  out  7  ones digit of head router index, active-low segments.
- hex_data  out  7  head payload bits [3:0] as hex digit 0-F, active-low segments.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - All internal registers are 0.
  - evt_count = 0, overflow = 0.
  - All hex outputs = 7'b1111111 (blank).
- Arrival detection:
  - valid_q[r] registers bit PKT_W-1 of each router every cycle.
  - arrival[r] = valid & ~valid_q. A packet held valid for many cycles logs exactly once.
  - Payload is sampled into a per-router holding register on the arrival cycle.
- Pending set:
  - pending |= arrival every cycle.
  - Each cycle, the lowest-index pending bit is logged and cleared.
  - If the same router re-arrives while still pending, it stays one pending bit, and its holding register takes the newer payload.
- Latency counter:
  - Cleared to 0 on the cycle inject rises (0→1).
  - Increments each cycle while inject has been seen. Saturates at 2^LAT_W-1 (no wrap).
  - The value is stamped at logging time. Simultaneous arrivals therefore get stamps differing by +1 per queue position.
- FIFO:
  - Entry = {idx, payload, lat}. One write per cycle at most.
  - Full: the entry is dropped and overflow is set (sticky until rst or sw_clear).
  - Pointers wrap modulo DEPTH. evt_count is registered.
- Key handling:
  - key_next is edge-detected with a flag register; a 0→1 transition is one pop.
  - Pop when empty: ignored.
  - Write and pop in the same cycle: both happen, count unchanged. When full, the write is accepted because the pop frees a slot.
- Display FSM, two states:
  - EMPTY: all digits show dash (~7'b0000001). Go to SHOW when count becomes nonzero.
  - SHOW: hex_router_hi/lo = idx/10 and idx%10, hex_data = payload[3:0]. Go to EMPTY when count becomes 0.
  - Index values above 99 are impossible with the default N_ROUTERS; the tens digit only decodes 0-4.
- sw_clear:
  - Synchronous. Empties the FIFO, pending set and overflow flag, and zeroes the latency counter.
  - Has priority over a simultaneous write or pop.
- rst mid-operation: everything returns to reset values immediately (asynchronously), including pending arrivals.
- Hex outputs are registered, so the display follows FIFO head changes with 1-cycle latency.

Decomposition:
- Shared package holds:
  - constants N_ROUTERS, PKT_W, IDX_W, DEPTH, LAT_W;
  - the segment patterns for 0-F, dash and blank;
  - the event entry typedef {idx, payload, lat}.
- Sub-module seg7_decode: 4-bit value in, active-low 7-bit pattern out, dash for invalid codes. Instantiated three times.

Test Plan:
- Reset: assert rst with traffic present → evt_count=0, overflow=0, all hex=7'b1111111. Release rst → FSM goes to EMPTY and the hex outputs show dash.
- Single arrival: inject rises at cycle 0; router 17 presents {1, 12'h005} at cycle 5 → one entry {17, 5, lat≈5 per stamp rule}. evt_count=1, hex_router_hi="1", hex_router_lo="7", hex_data="5".
- Simultaneous arrivals: routers 40 and 3 go valid in the same cycle → entries logged in order 3 then 40 on consecutive cycles, lat differing by 1, evt_count=2.
- Held valid: router 8 held valid for 20 cycles, then released and reasserted → exactly two entries.
- Overflow: 9 distinct arrivals, no pops → evt_count=8, overflow=1, the 9th is absent. One key_next press → evt_count=7, display advances to the second entry. Pop on an empty FIFO has no effect.
- Clear/reset mid-stream: sw_clear with 3 entries and 2 pending → count=0, overflow=0, nothing is logged afterwards. Key held high across the clear → no extra pop.

Source files
------------

// File: rtl/packet_receive_monitor_pkg.sv
// Shared constants, event record and 7-segment patterns for the packet receive monitor.
package packet_receive_monitor_pkg;

    localparam int N_ROUTERS = 49;
    localparam int PKT_W     = 13;
    localparam int IDX_W     = 6;
    localparam int DEPTH     = 8;
    localparam int LAT_W     = 8;
    localparam int PTR_W     = $clog2(DEPTH);

    // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [PKT_W-2:0] payload;
        logic [LAT_W-1:0] lat;
    } event_t;

    typedef enum logic {
        DISP_EMPTY = 1'b0,
        DISP_SHOW  = 1'b1
    } disp_state_e;

    function automatic logic [6:0] seg_pattern(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/packet_receive_monitor_seg7_decode.sv
// Active-low 7-segment decoder; codes above MAX_VAL render as a dash.
module packet_receive_monitor_seg7_decode
    import packet_receive_monitor_pkg::*;
#(
    parameter int MAX_VAL = 15
) (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (int'(value) <= MAX_VAL) begin
            seg = seg_pattern(value);
        end
    end

endmodule

// File: rtl/packet_receive_monitor.sv
// Detects router packet arrivals, logs {idx, payload, latency} into a small FIFO
// and shows the FIFO head on three 7-segment displays; a key press pops the head.
module packet_receive_monitor
    import packet_receive_monitor_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ROUTERS*PKT_W-1:0] in_routers,
    input  logic                       inject,
    input  logic                       key_next,
    input  logic                       sw_clear,
    output logic [IDX_W-1:0]           evt_count,
    output logic                       overflow,
    output logic [6:0]                 hex_router_hi,
    output logic [6:0]                 hex_router_lo,
    output logic [6:0]                 hex_data
);

    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [N_ROUTERS-1:0] valid_now, valid_q_reg, arrival;
    logic [N_ROUTERS-1:0] pending_reg, pending_next, grant;
    logic [PKT_W-2:0]     hold_reg [N_ROUTERS];
    logic [IDX_W-1:0]     sel_idx;
    logic                 log_valid;
    event_t               log_entry;

    logic                 inject_q_reg, seen_reg;
    logic [LAT_W-1:0]     lat_reg;
    logic                 inject_rise;

    event_t               mem_reg [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [IDX_W-1:0]     count_reg;
    logic                 ovf_reg, key_q_reg;
    logic                 pop, full, wr_accept;

    disp_state_e          state_reg, state_next;
    logic [IDX_W-1:0]     head_idx;
    logic [3:0]           tens, ones, data_nib;
    logic [6:0]           seg_hi, seg_lo, seg_data;
    logic [6:0]           hex_hi_reg, hex_lo_reg, hex_data_reg;
    logic [6:0]           hex_hi_next, hex_lo_next, hex_data_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_ROUTERS; gi++) begin : g_router
            assign valid_now[gi] = in_routers[gi*PKT_W + PKT_W-1];
            assign arrival[gi]   = valid_now[gi] & ~valid_q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q_reg <= '0;
            for (int r = 0; r < N_ROUTERS; r++) hold_reg[r] <= '0;
        end else begin
            valid_q_reg <= valid_now;
            for (int r = 0; r < N_ROUTERS; r++) begin
                if (arrival[r]) hold_reg[r] <= in_routers[r*PKT_W +: PKT_W-1];
            end
        end
    end

    // Lowest-index pending router wins the single log slot this cycle.
    always_comb begin
        sel_idx = '0;
        for (int r = N_ROUTERS-1; r >= 0; r--) begin
            if (pending_reg[r]) sel_idx = IDX_W'(r);
        end
    end

    assign log_valid    = |pending_reg;
    assign grant        = log_valid ? (N_ROUTERS'(1) << sel_idx) : '0;
    assign pending_next = (pending_reg & ~grant) | arrival;
    assign log_entry    = '{idx: sel_idx, payload: hold_reg[sel_idx], lat: lat_reg};

    assign inject_rise = inject & ~inject_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inject_q_reg <= 1'b0;
            seen_reg     <= 1'b0;
            lat_reg      <= '0;
        end else begin
            inject_q_reg <= inject;
            if (inject_rise) seen_reg <= 1'b1;
            if (sw_clear || inject_rise) lat_reg <= '0;
            else if (seen_reg && lat_reg != LAT_MAX) lat_reg <= lat_reg + LAT_W'(1);
        end
    end

    assign pop       = key_next & ~key_q_reg & (count_reg != '0);
    assign full      = (count_reg == IDX_W'(DEPTH));
    assign wr_accept = log_valid & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            key_q_reg   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            key_q_reg <= key_next;
            if (sw_clear) begin
                pending_reg <= '0;
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                ovf_reg     <= 1'b0;
            end else begin
                pending_reg <= pending_next;
                if (wr_accept) begin
                    mem_reg[wr_ptr_reg] <= log_entry;
                    wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                if (log_valid && !wr_accept) ovf_reg <= 1'b1;
                case ({wr_accept, pop})
                    2'b10:   count_reg <= count_reg + IDX_W'(1);
                    2'b01:   count_reg <= count_reg - IDX_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    assign head_idx = mem_reg[rd_ptr_reg].idx;
    assign tens     = 4'(head_idx / IDX_W'(10));
    assign ones     = 4'(head_idx % IDX_W'(10));
    assign data_nib = mem_reg[rd_ptr_reg].payload[3:0];

    packet_receive_monitor_seg7_decode #(.MAX_VAL(4))  u_seg_hi   (.value(tens),     .seg(seg_hi));
    packet_receive_monitor_seg7_decode #(.MAX_VAL(9))  u_seg_lo   (.value(ones),     .seg(seg_lo));
    packet_receive_monitor_seg7_decode #(.MAX_VAL(15)) u_seg_data (.value(data_nib), .seg(seg_data));

    // Digits are driven from the next state so the display trails the FIFO head by one cycle.
    always_comb begin
        state_next    = state_reg;
        hex_hi_next   = SEG_DASH;
        hex_lo_next   = SEG_DASH;
        hex_data_next = SEG_DASH;
        case (state_reg)
            DISP_EMPTY: if (count_reg != '0) state_next = DISP_SHOW;
            DISP_SHOW:  if (count_reg == '0) state_next = DISP_EMPTY;
            default:    state_next = DISP_EMPTY;
        endcase
        if (state_next == DISP_SHOW) begin
            hex_hi_next   = seg_hi;
            hex_lo_next   = seg_lo;
            hex_data_next = seg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= DISP_EMPTY;
            hex_hi_reg   <= SEG_BLANK;
            hex_lo_reg   <= SEG_BLANK;
            hex_data_reg <= SEG_BLANK;
        end else begin
            state_reg    <= state_next;
            hex_hi_reg   <= hex_hi_next;
            hex_lo_reg   <= hex_lo_next;
            hex_data_reg <= hex_data_next;
        end
    end

    assign evt_count     = count_reg;
    assign overflow      = ovf_reg;
    assign hex_router_hi = hex_hi_reg;
    assign hex_router_lo = hex_lo_reg;
    assign hex_data      = hex_data_reg;

endmodule
